// File: rtl/xpe_post_pipe.sv
// Post-processing stage behind the NPE: accumulates partial-sum vectors, adds an optional bias,
// then rounds, shifts, applies ReLU and saturates each lane before handing the vector to the IO buffer.
module xpe_post_lane #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_bias,
  input  logic [4:0]       i_shift,
  input  logic             i_relu_en,
  output logic [OUT_W-1:0] o_res
);
  localparam int W = ACC_W + 2;
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [W-1:0] sum, rnd, shd;

  always_comb begin
    sum = $signed({{2{i_acc[ACC_W-1]}}, i_acc}) + $signed({{2{i_bias[ACC_W-1]}}, i_bias});
    rnd = '0;
    if (i_shift != 5'd0) rnd = {{(W-1){1'b0}}, 1'b1} << (i_shift - 5'd1);
    shd = (sum + rnd) >>> i_shift;
    if (i_relu_en && shd[W-1]) shd = '0;
    if (shd > MAX_V)      o_res = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shd < MIN_V) o_res = {1'b1, {(OUT_W-1){1'b0}}};
    else                  o_res = shd[OUT_W-1:0];
  end
endmodule

module xpe_post_pipe #(
  parameter int CH      = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int BADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [4:0]            i_part_num,
  input  logic [7:0]            i_out_piece,
  input  logic [BADDR_W-1:0]    i_addr_start_b,
  input  logic [4:0]            i_shift,
  input  logic                  i_bias_en,
  input  logic                  i_relu_en,
  input  logic [CH*ACC_W-1:0]   i_in_data,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [BADDR_W-1:0]    o_b_addr,
  output logic                  o_b_rd_en,
  input  logic [CH*ACC_W-1:0]   i_b_data,
  input  logic                  i_b_valid,
  output logic [CH*OUT_W-1:0]   o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_OUT} state_t;
  typedef struct packed {
    logic [4:0]         part_num;
    logic [7:0]         out_piece;
    logic [BADDR_W-1:0] addr_start_b;
    logic [4:0]         shift;
    logic               bias_en;
    logic               relu_en;
  } cfg_t;

  state_t state_q, state_d;
  cfg_t   cfg_q, cfg_d;
  logic [7:0]         piece_idx_q, piece_idx_d;
  logic [4:0]         beat_cnt_q, beat_cnt_d;
  logic [BADDR_W-1:0] b_addr_q, b_addr_d;
  logic               b_rd_en_q, b_rd_en_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  logic [CH-1:0][ACC_W-1:0] acc_q, acc_d, in_vec, b_vec, in_sum, lane_acc, lane_bias;
  logic [CH-1:0][OUT_W-1:0] lane_res, out_data_q, out_data_d;

  logic [4:0] part_eff;
  logic [7:0] piece_eff;
  logic       beat_ok, last_beat, last_piece;

  assign in_vec     = i_in_data;
  assign b_vec      = i_b_data;
  assign part_eff   = (cfg_q.part_num == 5'd0) ? 5'd1 : cfg_q.part_num;
  assign piece_eff  = (cfg_q.out_piece == 8'd0) ? 8'd1 : cfg_q.out_piece;
  assign beat_ok    = (state_q == S_ACC) && i_in_valid;
  assign last_beat  = (beat_cnt_q == part_eff - 5'd1);
  assign last_piece = (piece_idx_q == piece_eff - 8'd1);

  // Lanes see the running sum (incl. the beat now arriving) in ACC, and acc+bias in BIAS,
  // so the result can be registered on the very cycle the vector completes.
  for (genvar k = 0; k < CH; k++) begin : g_lane
    assign in_sum[k]    = (beat_cnt_q == 5'd0) ? in_vec[k] : acc_q[k] + in_vec[k];
    assign lane_acc[k]  = (state_q == S_BIAS) ? acc_q[k] : in_sum[k];
    assign lane_bias[k] = (state_q == S_BIAS) ? b_vec[k] : '0;
    xpe_post_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
      .i_acc     (lane_acc[k]),
      .i_bias    (lane_bias[k]),
      .i_shift   (cfg_q.shift),
      .i_relu_en (cfg_q.relu_en),
      .o_res     (lane_res[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    piece_idx_d = piece_idx_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    b_addr_d    = b_addr_q;
    b_rd_en_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        cfg_d       = '{part_num: i_part_num, out_piece: i_out_piece, addr_start_b: i_addr_start_b,
                        shift: i_shift, bias_en: i_bias_en, relu_en: i_relu_en};
        piece_idx_d = '0;
        beat_cnt_d  = '0;
        state_d     = S_ACC;
      end
      S_ACC: if (beat_ok) begin
        acc_d = in_sum;
        if (last_beat) begin
          beat_cnt_d = '0;
          if (cfg_q.bias_en) begin
            state_d   = S_BIAS;
            b_rd_en_d = 1'b1;
            b_addr_d  = cfg_q.addr_start_b + BADDR_W'(piece_idx_q);
          end else begin
            state_d     = S_OUT;
            out_data_d  = lane_res;
            out_valid_d = 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 5'd1;
        end
      end
      S_BIAS: if (i_b_valid) begin
        out_data_d  = lane_res;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: if (i_out_ready) begin
        out_valid_d = 1'b0;
        if (last_piece) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          piece_idx_d = piece_idx_q + 8'd1;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      piece_idx_q <= '0;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      b_addr_q    <= '0;
      b_rd_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      piece_idx_q <= piece_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      b_addr_q    <= b_addr_d;
      b_rd_en_q   <= b_rd_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign o_in_ready  = (state_q == S_ACC);
  assign o_busy      = (state_q != S_IDLE);
  assign o_b_addr    = b_addr_q;
  assign o_b_rd_en   = b_rd_en_q;
  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_done      = done_q;
endmodule

// File: tb/tb_xpe_post_pipe.sv
// Bench for xpe_post_pipe: table of jobs with hand-computed lane-0 results, a scoreboard checked
// on every output handshake, plus directed back-pressure and mid-job reset sequences.
module tb_xpe_post_pipe;
  localparam int CH = 16, ACC_W = 32, OUT_W = 16, BADDR_W = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic i_start = 1'b0, i_bias_en = 1'b0, i_relu_en = 1'b0;
  logic [4:0] i_part_num = '0, i_shift = '0;
  logic [7:0] i_out_piece = '0;
  logic [BADDR_W-1:0] i_addr_start_b = '0;
  logic [CH*ACC_W-1:0] i_in_data = '0, i_b_data = '0;
  logic i_in_valid = 1'b0, i_b_valid = 1'b0, i_out_ready = 1'b1;
  logic o_in_ready, o_b_rd_en, o_out_valid, o_busy, o_done;
  logic [BADDR_W-1:0] o_b_addr;
  logic [CH*OUT_W-1:0] o_out_data;

  always #5 clk = ~clk;

  xpe_post_pipe #(.CH(CH), .ACC_W(ACC_W), .OUT_W(OUT_W), .BADDR_W(BADDR_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_part_num(i_part_num), .i_out_piece(i_out_piece),
    .i_addr_start_b(i_addr_start_b), .i_shift(i_shift), .i_bias_en(i_bias_en), .i_relu_en(i_relu_en),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_b_addr(o_b_addr),
    .o_b_rd_en(o_b_rd_en), .i_b_data(i_b_data), .i_b_valid(i_b_valid), .o_out_data(o_out_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    int pn; int op; int addr; int sh; bit ben; bit ren;
    int b0; int b1; int b2; int bias; int exp0; int hold;
  } vec_t;
  vec_t vt[11];

  logic [CH*OUT_W-1:0] sb[$];
  int n_cmp = 0, n_fail = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference requantiser in plain 64-bit integer arithmetic.
  function automatic logic [OUT_W-1:0] ref_q(input longint s, input int sh, input bit relu);
    longint v;
    v = s;
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[OUT_W-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && o_out_valid && i_out_ready) begin
      logic [CH*OUT_W-1:0] e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h want no output", o_out_data);
      end else begin
        e = sb.pop_front();
        if (o_out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %h want %h", o_out_data, e);
        end
      end
    end
  end

  task automatic run_job(input vec_t v);
    int np, no, n, acc15;
    int beats[3];
    logic [CH*OUT_W-1:0] e;
    beats[0] = v.b0; beats[1] = v.b1; beats[2] = v.b2;
    np = (v.pn == 0) ? 1 : v.pn;
    no = (v.op == 0) ? 1 : v.op;
    e = '0;
    i_out_ready = (v.hold == 0);
    i_part_num = 5'(v.pn); i_out_piece = 8'(v.op); i_addr_start_b = 8'(v.addr);
    i_shift = 5'(v.sh); i_bias_en = v.ben; i_relu_en = v.ren;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    // Scramble config inputs: only the values latched at start may matter.
    i_part_num = 5'd7; i_shift = 5'd9; i_bias_en = ~v.ben; i_relu_en = ~v.ren; i_addr_start_b = 8'hAA;
    chk("busy_start", o_busy, 1);
    for (int p = 0; p < no; p++) begin
      acc15 = 0;
      for (int b = 0; b < np; b++) begin
        i_in_data = '0;
        i_in_data[0 +: ACC_W] = beats[b];
        i_in_data[15*ACC_W +: ACC_W] = -beats[b];
        acc15 = acc15 - beats[b];
        i_in_valid = 1'b1;
        i_b_valid = 1'b1;
        i_b_data = '1;
        n = 0;
        while (!o_in_ready && n < 50) begin tick; n++; end
        if (n == 50) chk("in_ready_timeout", 0, 1);
        if (b == np - 1) begin
          e = '0;
          e[0 +: OUT_W] = 16'(v.exp0);
          e[15*OUT_W +: OUT_W] = ref_q(longint'(acc15) + (v.ben ? longint'(-v.bias) : 0), v.sh, v.ren);
          sb.push_back(e);
        end
        tick;
      end
      i_in_valid = 1'b0; i_b_valid = 1'b0; i_in_data = '0; i_b_data = '0;
      if (v.ben) begin
        chk("b_rd_en", o_b_rd_en, 1);
        chk("b_addr", o_b_addr, (v.addr + p) % 256);
        tick;
        chk("b_rd_en_pulse", o_b_rd_en, 0);
        repeat (p + 1) tick;
        chk("wait_bias_valid", o_out_valid, 0);
        i_b_data[0 +: ACC_W] = v.bias;
        i_b_data[15*ACC_W +: ACC_W] = -v.bias;
        i_b_valid = 1'b1;
        tick;
        i_b_valid = 1'b0; i_b_data = '0;
      end
      chk("latency_valid", o_out_valid, 1);
      if (v.hold > 0) begin
        for (int h = 0; h < v.hold; h++) begin
          i_start = (h == 1);
          tick;
          chk("hold_valid", o_out_valid, 1);
          chk("hold_in_ready", o_in_ready, 0);
          chk("hold_done", o_done, 0);
          n_cmp++;
          if (o_out_data !== e) begin
            n_fail++;
            $display("FAIL hold_data: got %h want %h", o_out_data, e);
          end
        end
        i_start = 1'b0;
        i_out_ready = 1'b1;
      end
      tick;
      chk("done", o_done, (p == no - 1) ? 1 : 0);
    end
    tick;
    chk("done_pulse", o_done, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    vt[0]  = '{1, 1, 0,   0, 1'b0, 1'b0, 3, 0, 0, 0, 3, 0};
    vt[1]  = '{3, 1, 0,   1, 1'b0, 1'b0, 3, 5, 7, 0, 8, 0};
    vt[2]  = '{1, 2, 4,   0, 1'b1, 1'b1, 10, 0, 0, -20, 0, 0};
    vt[3]  = '{1, 2, 4,   0, 1'b1, 1'b0, 10, 0, 0, -20, -10, 0};
    vt[4]  = '{1, 1, 0,   0, 1'b0, 1'b0, 32'h7FFFFFFF, 0, 0, 0, 32767, 0};
    vt[5]  = '{1, 1, 0,   0, 1'b0, 1'b0, -100000, 0, 0, 0, -32768, 0};
    vt[6]  = '{2, 1, 0,   0, 1'b0, 1'b0, 32'h7FFFFFFF, 1, 0, 0, -32768, 0};
    vt[7]  = '{0, 0, 0,   2, 1'b0, 1'b0, 42, 0, 0, 0, 11, 0};
    vt[8]  = '{1, 1, 0,   3, 1'b0, 1'b0, -12, 0, 0, 0, -1, 0};
    vt[9]  = '{2, 2, 255, 2, 1'b1, 1'b0, 100, -30, 0, 7, 19, 0};
    vt[10] = '{1, 1, 0,   0, 1'b0, 1'b0, 5, 0, 0, 0, 5, 5};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {o_out_valid, o_busy, o_done, o_b_rd_en, o_in_ready, o_b_addr}, 0);
    chk("rst_data_lo", o_out_data[63:0], 0);
    rst = 1'b0;
    tick;

    foreach (vt[i]) run_job(vt[i]);

    // Reset while waiting for bias aborts the job silently.
    i_part_num = 5'd1; i_out_piece = 8'd1; i_addr_start_b = 8'd4; i_shift = 5'd0;
    i_bias_en = 1'b1; i_relu_en = 1'b0; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    i_in_data = '0; i_in_data[0 +: ACC_W] = 10; i_in_valid = 1'b1;
    tick;
    i_in_valid = 1'b0;
    chk("v6_in_bias", o_b_rd_en, 1);
    tick;
    rst = 1'b1;
    #1;
    chk("v6_rst_ctrl", {o_out_valid, o_busy, o_done, o_b_rd_en, o_in_ready, o_b_addr}, 0);
    n_cmp++;
    if (o_out_data !== '0) begin
      n_fail++;
      $display("FAIL v6_rst_data: got %h want 0", o_out_data);
    end
    tick; tick;
    rst = 1'b0;
    i_b_data = '1; i_b_valid = 1'b1;
    tick;
    i_b_valid = 1'b0; i_b_data = '0;
    for (int c = 0; c < 3; c++) begin
      chk("v6_no_done", o_done, 0);
      chk("v6_no_valid", o_out_valid, 0);
      tick;
    end
    run_job(vt[0]);
    run_job(vt[3]);

    repeat (3) tick;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
